mux_arb_n: RTL and testbench

//   N-channel arbitrated multiplexer with valid/ready handshake and one registered output stage.

---
 rtl/mux_pkg.sv | 19 +
 rtl/mux_arb_n_rr_arbiter.sv | 52 +++++
 rtl/mux_arb_n.sv | 75 +++++++
 tb/tb_mux_arb_n.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and width helpers for the arbitrated mux family.
package mux_pkg;

    localparam int unsigned MODE_FIXED = 0;
    localparam int unsigned MODE_RR    = 1;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return r;
    endfunction

    // Select index width; a single-channel mux still carries a 1-bit index.
    function automatic int unsigned sel_width(input int unsigned channels);
        return (channels > 1) ? clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/mux_arb_n_rr_arbiter.sv
// One-hot arbiter: fixed priority or round-robin with a pointer that moves only on transfer.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int unsigned CHANNELS = 4,
    parameter  int unsigned MODE     = MODE_RR,
    localparam int unsigned SW       = sel_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [CHANNELS-1:0] req,
    input  logic                advance,
    output logic [CHANNELS-1:0] grant,
    output logic [SW-1:0]       grant_idx
);

    logic [SW-1:0] r_ptr;
    logic [SW-1:0] w_base;
    logic          w_found;

    assign w_base = (MODE == MODE_RR) ? r_ptr : '0;

    // Two ordered passes implement the wrap: indices at/after the base first, then from 0.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (!w_found && req[k] && (SW'(k) >= w_base)) begin
                grant[k]  = 1'b1;
                grant_idx = SW'(k);
                w_found   = 1'b1;
            end
        end
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (!w_found && req[k]) begin
                grant[k]  = 1'b1;
                grant_idx = SW'(k);
                w_found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr <= '0;
        end else if (advance && (MODE == MODE_RR)) begin
            r_ptr <= (grant_idx == SW'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/mux_arb_n.sv
// N-channel arbitrated mux with valid/ready handshake and a single registered output stage.
module mux_arb_n
    import mux_pkg::*;
#(
    parameter  int unsigned BITS     = 32,
    parameter  int unsigned CHANNELS = 4,
    parameter  int unsigned MODE     = MODE_RR,
    localparam int unsigned SW       = sel_width(CHANNELS)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [CHANNELS-1:0]      in_valid,
    input  logic [CHANNELS*BITS-1:0] in_data,
    output logic [CHANNELS-1:0]      in_ready,
    output logic                     out_valid,
    output logic [BITS-1:0]          out_data,
    output logic [SW-1:0]            out_sel,
    input  logic                     out_ready
);

    logic                r_out_valid;
    logic [BITS-1:0]     r_out_data;
    logic [SW-1:0]       r_out_sel;

    logic                w_load;
    logic                w_xfer;
    logic [CHANNELS-1:0] w_grant;
    logic [SW-1:0]       w_grant_idx;
    logic [BITS-1:0]     w_data;

    assign w_load   = ~r_out_valid | out_ready;
    assign in_ready = w_grant & {CHANNELS{w_load & rstn}};
    assign w_xfer   = |(in_valid & in_ready);

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .MODE     (MODE)
    ) u_arb (
        .clk       (clk),
        .rstn      (rstn),
        .req       (in_valid),
        .advance   (w_xfer),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    // AND-OR select: a non-granted channel is masked to zero, so its X never reaches the output.
    always_comb begin
        w_data = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            w_data = w_data | (in_data[k*BITS +: BITS] & {BITS{w_grant[k]}});
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_load) begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_data;
                r_out_sel   <= w_grant_idx;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux_arb_n.sv
// Bench for mux_arb_n: RR 4x32, fixed 4x32 and RR 3x8 instances against a cycle-level reference model.
module tb_mux_arb_n;
    import mux_pkg::*;

    localparam int NU = 3;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  mv    [NU];
    logic [31:0] md    [NU][4];
    logic        mordy [NU];

    logic [3:0]   v0, v1, ir0, ir1;
    logic [2:0]   v2, ir2;
    logic [127:0] d0, d1;
    logic [23:0]  d2;
    logic         ov0, ov1, ov2;
    logic [31:0]  od0, od1;
    logic [7:0]   od2;
    logic [1:0]   os0, os1, os2;

    assign v0 = mv[0];
    assign v1 = mv[1];
    assign v2 = mv[2][2:0];

    always_comb begin
        d0 = '0;
        d1 = '0;
        d2 = '0;
        for (int k = 0; k < 4; k++) begin
            d0[k*32 +: 32] = md[0][k];
            d1[k*32 +: 32] = md[1][k];
        end
        for (int k = 0; k < 3; k++) d2[k*8 +: 8] = md[2][k][7:0];
    end

    mux_arb_n #(.BITS(32), .CHANNELS(4), .MODE(MODE_RR)) u_rr (
        .clk(clk), .rstn(rstn), .in_valid(v0), .in_data(d0), .in_ready(ir0),
        .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(mordy[0]));

    mux_arb_n #(.BITS(32), .CHANNELS(4), .MODE(MODE_FIXED)) u_fix (
        .clk(clk), .rstn(rstn), .in_valid(v1), .in_data(d1), .in_ready(ir1),
        .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(mordy[1]));

    mux_arb_n #(.BITS(8), .CHANNELS(3), .MODE(MODE_RR)) u_rr3 (
        .clk(clk), .rstn(rstn), .in_valid(v2), .in_data(d2), .in_ready(ir2),
        .out_valid(ov2), .out_data(od2), .out_sel(os2), .out_ready(mordy[2]));

    // Reference model state, one entry per instance.
    int          ptr  [NU];
    logic        ov_m [NU];
    logic [31:0] od_m [NU];
    int          os_m [NU];
    int          gnt  [NU];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int nch(int u);
        return (u == 2) ? 3 : 4;
    endfunction

    function automatic int is_rr(int u);
        return (u == 1) ? 0 : 1;
    endfunction

    function automatic logic [31:0] dmask(int u);
        return (u == 2) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [63:0] dut_ir(int u);
        case (u)
            0:       return 64'(ir0);
            1:       return 64'(ir1);
            default: return 64'(ir2);
        endcase
    endfunction

    function automatic logic [63:0] dut_ov(int u);
        case (u)
            0:       return 64'(ov0);
            1:       return 64'(ov1);
            default: return 64'(ov2);
        endcase
    endfunction

    function automatic logic [63:0] dut_od(int u);
        case (u)
            0:       return 64'(od0);
            1:       return 64'(od1);
            default: return 64'(od2);
        endcase
    endfunction

    function automatic logic [63:0] dut_os(int u);
        case (u)
            0:       return 64'(os0);
            1:       return 64'(os1);
            default: return 64'(os2);
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Winning channel this cycle, or -1 when nothing transfers.
    function automatic int mgrant(int u);
        int n;
        int base;
        int k;
        n    = nch(u);
        base = (is_rr(u) != 0) ? ptr[u] : 0;
        if (ov_m[u] && !mordy[u]) return -1;
        for (int i = 0; i < n; i++) begin
            k = (base + i) % n;
            if (mv[u][k]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < NU; u++) begin
            ptr[u]  = 0;
            ov_m[u] = 1'b0;
            od_m[u] = '0;
            os_m[u] = 0;
            gnt[u]  = -1;
        end
    endtask

    task automatic check_outs();
        for (int u = 0; u < NU; u++) begin
            check($sformatf("u%0d out_valid", u), dut_ov(u), 64'(ov_m[u]));
            check($sformatf("u%0d out_data", u),  dut_od(u), 64'(od_m[u]));
            check($sformatf("u%0d out_sel", u),   dut_os(u), 64'(os_m[u]));
        end
    endtask

    // Called at a negedge with inputs settled; returns at the next negedge.
    task automatic step();
        #1;
        for (int u = 0; u < NU; u++) begin
            gnt[u] = mgrant(u);
            check($sformatf("u%0d in_ready", u), dut_ir(u),
                  (gnt[u] >= 0) ? (64'd1 << gnt[u]) : 64'd0);
        end
        @(posedge clk);
        for (int u = 0; u < NU; u++) begin
            if (!ov_m[u] || mordy[u]) begin
                if (gnt[u] >= 0) begin
                    ov_m[u] = 1'b1;
                    od_m[u] = md[u][gnt[u]] & dmask(u);
                    os_m[u] = gnt[u];
                    if (is_rr(u) != 0) ptr[u] = (gnt[u] + 1) % nch(u);
                end else begin
                    ov_m[u] = 1'b0;
                end
            end
        end
        @(negedge clk);
        check_outs();
    endtask

    task automatic reload_granted();
        for (int u = 0; u < NU; u++)
            if (gnt[u] >= 0) md[u][gnt[u]] = $urandom;
    endtask

    task automatic set_all(input logic [3:0] v, input logic rdy);
        for (int u = 0; u < NU; u++) begin
            mv[u]    = v;
            mordy[u] = rdy;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [1:0]  s_hold;
        logic [31:0] d_hold;

        for (int u = 0; u < NU; u++)
            for (int k = 0; k < 4; k++) md[u][k] = $urandom;
        set_all(4'hF, 1'b1);
        model_reset();

        // Reset state, including in_ready forced low while reset is held.
        repeat (2) @(negedge clk);
        #1;
        for (int u = 0; u < NU; u++)
            check($sformatf("u%0d in_ready in reset", u), dut_ir(u), 64'd0);
        check_outs();
        set_all(4'h0, 1'b1);
        @(negedge clk);
        rstn = 1'b1;

        // Load 0xDEAD, stall on it, then reset between edges.
        for (int u = 0; u < NU; u++) md[u][0] = 32'h0000_DEAD;
        set_all(4'h1, 1'b0);
        step();
        step();
        check("u0 pre-reset out_valid", 64'(ov0), 64'd1);
        check("u0 pre-reset out_data",  64'(od0), 64'h0000_DEAD);
        set_all(4'hF, 1'b1);
        #2 rstn = 1'b0;
        #1;
        check("u0 async reset out_valid", 64'(ov0), 64'd0);
        check("u0 async reset out_data",  64'(od0), 64'd0);
        check("u0 async reset in_ready",  64'(ir0), 64'd0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;

        // All channels requesting: RR order starts at 0 after reset and wraps.
        for (int i = 0; i < 8; i++) begin
            step();
            check("u0 rr seq", 64'(os0), 64'(i % 4));
            check("u0 no bubble", 64'(ov0), 64'd1);
            check("u2 rr seq", 64'(os2), 64'(i % 3));
            check("u1 fixed sel", 64'(os1), 64'd0);
            reload_granted();
        end

        // Stall: outputs frozen, no ready, pointer frozen.
        set_all(4'hF, 1'b0);
        s_hold = os0;
        d_hold = od0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("u0 stall sel",  64'(os0), 64'(s_hold));
            check("u0 stall data", 64'(od0), 64'(d_hold));
        end
        set_all(4'hF, 1'b1);
        step();
        check("u0 resume sel", 64'(os0), 64'((s_hold + 2'd1) % 4));
        reload_granted();

        // Fixed priority with 1010 requesting.
        set_all(4'b1010, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1 check("u1 fixed in_ready", 64'(ir1), 64'b0010);
            step();
            check("u1 fixed out_sel", 64'(os1), 64'd1);
            reload_granted();
        end

        // Single one-cycle request on channel 2.
        set_all(4'b0100, 1'b1);
        step();
        check("u0 single valid", 64'(ov0), 64'd1);
        check("u0 single sel",   64'(os0), 64'd2);
        d_hold = od0;
        set_all(4'h0, 1'b1);
        step();
        check("u0 single drop valid", 64'(ov0), 64'd0);
        check("u0 single hold data",  64'(od0), 64'(d_hold));

        // Randomized producers that obey the handshake; idle channels carry X data.
        for (int u = 0; u < NU; u++)
            for (int k = 0; k < 4; k++) md[u][k] = 'x;
        for (int c = 0; c < 400; c++) begin
            for (int u = 0; u < NU; u++) mordy[u] = ($urandom % 4) != 0;
            step();
            for (int u = 0; u < NU; u++) begin
                for (int k = 0; k < nch(u); k++) begin
                    if (gnt[u] == k) begin
                        if (($urandom % 2) != 0) begin
                            mv[u][k] = 1'b0;
                            md[u][k] = 'x;
                        end else begin
                            md[u][k] = $urandom;
                        end
                    end else if (!mv[u][k] && ($urandom % 3) == 0) begin
                        mv[u][k] = 1'b1;
                        md[u][k] = $urandom;
                    end
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
